// File: rtl/cnt_stream_rd_fifo_pkg.sv
// Shared types and constants for the count-record read FIFO.
// Record layout, word width and read-serializer state encoding.
package cnt_stream_rd_fifo_pkg;

  localparam int REC_W     = 64;
  localparam int WORD_W    = 32;
  localparam int GATE_BIT  = 63;
  localparam int DELTA_MSB = 62;
  localparam int DELTA_LSB = 32;
  localparam int CLK_MSB   = 31;
  localparam int CLK_LSB   = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2
  } rd_state_t;

endpackage

// File: rtl/cnt_stream_rd_fifo_fifo.sv
// Circular record store with wrap-bit pointers.
// Read data is the entry at the read pointer (show-ahead).
module sync_fifo_64
  import cnt_stream_rd_fifo_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             FLUSH,
  input  logic             WR_EN,
  input  logic [REC_W-1:0] WR_DATA,
  input  logic             RD_EN,
  output logic [REC_W-1:0] RD_DATA,
  output logic             FULL,
  output logic             EMPTY,
  output logic [ADDR_W:0]  LEVEL
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [REC_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]  wptr;
  logic [ADDR_W:0]  rptr;

  assign EMPTY = (wptr == rptr);
  assign FULL  = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                 (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
  assign LEVEL = wptr - rptr;
  assign RD_DATA = mem[rptr[ADDR_W-1:0]];

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge CLK) begin
    if (WR_EN)
      mem[wptr[ADDR_W-1:0]] <= WR_DATA;
  end

  // Pointer update; flush realigns both pointers to empty.
  always_ff @(posedge CLK) begin
    if (RESET || FLUSH) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (WR_EN) wptr <= wptr + 1'b1;
      if (RD_EN) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/cnt_stream_rd_fifo.sv
// Buffers 64-bit count records and drains them as two 32-bit words.
// Tracks dropped records with a sticky flag and saturating counter.
module cnt_stream_rd_fifo
  import cnt_stream_rd_fifo_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DROP_W = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WR_VLD,
  input  logic [REC_W-1:0]  WR_DATA,
  input  logic              FLUSH,
  input  logic              CLR_OVF,
  output logic [WORD_W-1:0] RD_DATA,
  output logic              RD_VLD,
  input  logic              RD_ACK,
  output logic              RD_HI,
  output logic [ADDR_W:0]   LEVEL,
  output logic              OVF,
  output logic [DROP_W-1:0] DROP_CNT
);

  localparam logic [DROP_W-1:0] CNT_MAX = '1;

  rd_state_t        state;
  rd_state_t        state_nxt;
  logic [REC_W-1:0] hold;
  logic [REC_W-1:0] fifo_q;
  logic             full;
  logic             empty;
  logic             pop;
  logic             fifo_pop;
  logic             wr_en;
  logic             drop;

  assign fifo_pop = pop & ~FLUSH;
  assign wr_en    = WR_VLD & ~FLUSH & (~full | fifo_pop);
  assign drop     = WR_VLD & ~FLUSH & full & ~fifo_pop;

  sync_fifo_64 #(
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .CLK     (CLK),
    .RESET   (RESET),
    .FLUSH   (FLUSH),
    .WR_EN   (wr_en),
    .WR_DATA (WR_DATA),
    .RD_EN   (fifo_pop),
    .RD_DATA (fifo_q),
    .FULL    (full),
    .EMPTY   (empty),
    .LEVEL   (LEVEL)
  );

  // Serializer next state; LO pops straight into HI to avoid a bubble.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = ST_HI;
        end
      end
      ST_HI: begin
        if (RD_ACK) state_nxt = ST_LO;
      end
      ST_LO: begin
        if (RD_ACK) begin
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = ST_HI;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Serializer state and holding register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
      hold  <= '0;
    end else if (FLUSH) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
      if (fifo_pop) hold <= fifo_q;
    end
  end

  // Word select from the holding register.
  always_comb begin
    RD_VLD  = 1'b0;
    RD_HI   = 1'b0;
    RD_DATA = '0;
    unique case (1'b1)
      (state == ST_HI): begin
        RD_VLD  = 1'b1;
        RD_HI   = 1'b1;
        RD_DATA = {hold[GATE_BIT], hold[DELTA_MSB:DELTA_LSB]};
      end
      (state == ST_LO): begin
        RD_VLD  = 1'b1;
        RD_DATA = hold[CLK_MSB:CLK_LSB];
      end
      default: ;
    endcase
  end

  // Drop accounting; a drop outranks a concurrent clear.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      OVF      <= 1'b0;
      DROP_CNT <= '0;
    end else if (drop) begin
      OVF <= 1'b1;
      if (CLR_OVF)
        DROP_CNT <= {{(DROP_W-1){1'b0}}, 1'b1};
      else if (DROP_CNT != CNT_MAX)
        DROP_CNT <= DROP_CNT + 1'b1;
    end else if (CLR_OVF) begin
      OVF      <= 1'b0;
      DROP_CNT <= '0;
    end
  end

endmodule

// File: tb/tb_cnt_stream_rd_fifo.sv
// Directed bench for the count-record read FIFO.
// Second instance uses a 2-bit drop counter for saturation.
module tb_cnt_stream_rd_fifo;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        wr_vld, flush, clr_ovf, rd_ack;
  logic [63:0] wr_data;
  logic [31:0] rd_data;
  logic        rd_vld, rd_hi, ovf;
  logic [4:0]  level;
  logic [15:0] drop_cnt;

  logic        wr_vld2, clr_ovf2, flush2, rd_ack2;
  logic [31:0] rd_data2;
  logic        rd_vld2, rd_hi2, ovf2;
  logic [4:0]  level2;
  logic [1:0]  drop_cnt2;

  int passes = 0;
  int total  = 0;

  logic [63:0] exp_q [$];
  logic [63:0] r;

  always #5 CLK = ~CLK;

  cnt_stream_rd_fifo #(.ADDR_W(4), .DROP_W(16)) dut (
    .CLK(CLK), .RESET(RESET), .WR_VLD(wr_vld), .WR_DATA(wr_data),
    .FLUSH(flush), .CLR_OVF(clr_ovf), .RD_DATA(rd_data),
    .RD_VLD(rd_vld), .RD_ACK(rd_ack), .RD_HI(rd_hi),
    .LEVEL(level), .OVF(ovf), .DROP_CNT(drop_cnt)
  );

  cnt_stream_rd_fifo #(.ADDR_W(4), .DROP_W(2)) dut2 (
    .CLK(CLK), .RESET(RESET), .WR_VLD(wr_vld2), .WR_DATA(wr_data),
    .FLUSH(flush2), .CLR_OVF(clr_ovf2), .RD_DATA(rd_data2),
    .RD_VLD(rd_vld2), .RD_ACK(rd_ack2), .RD_HI(rd_hi2),
    .LEVEL(level2), .OVF(ovf2), .DROP_CNT(drop_cnt2)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] rec(input int i);
    logic [15:0] tag;
    tag = 16'hC0DE;
    return {tag, 16'(i), 32'(1000 + i)};
  endfunction

  initial begin
    RESET = 1'b1; wr_vld = 0; flush = 0; clr_ovf = 0; rd_ack = 0;
    wr_data = '0; wr_vld2 = 0; clr_ovf2 = 0; flush2 = 0; rd_ack2 = 0;
    tick(); tick();
    chk("rst_vld", rd_vld, 0);
    chk("rst_hi", rd_hi, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_drop", drop_cnt, 0);
    RESET = 1'b0;
    tick();

    // single record, ack held high
    wr_vld = 1; wr_data = 64'h8000_0005_0000_0064; rd_ack = 1;
    tick();
    wr_vld = 0;
    chk("t1_level1", level, 1);
    chk("t1_vld_t1", rd_vld, 0);
    tick();
    chk("t1_vld_t2", rd_vld, 1);
    chk("t1_hi", rd_hi, 1);
    chk("t1_hiword", rd_data, 32'h8000_0005);
    chk("t1_level0", level, 0);
    tick();
    chk("t1_lo", rd_hi, 0);
    chk("t1_loword", rd_data, 32'h0000_0064);
    chk("t1_lovld", rd_vld, 1);
    tick();
    chk("t1_idle", rd_vld, 0);
    chk("t1_level_end", level, 0);
    rd_ack = 0;

    // 19 strobes with no acks: 1 held + 16 queued + 2 dropped
    for (int i = 0; i < 19; i++) begin
      wr_vld = 1; wr_data = rec(i);
      if (i < 17) exp_q.push_back(rec(i));
      tick();
    end
    wr_vld = 0;
    chk("fill_level", level, 16);
    chk("fill_drop", drop_cnt, 2);
    chk("fill_ovf", ovf, 1);
    chk("fill_vld", rd_vld, 1);
    r = exp_q.pop_front();
    chk("fill_hold_hi", rd_data, {32'h0, r[63:32]});
    tick();
    chk("fill_stable", rd_data, {32'h0, r[63:32]});

    rd_ack = 1;
    tick();
    chk("r0_lo", rd_data, {32'h0, r[31:0]});

    // write while full, concurrent with the LO-state pop
    wr_vld = 1; wr_data = 64'hDEAD_BEEF_1234_5678;
    exp_q.push_back(64'hDEAD_BEEF_1234_5678);
    tick();
    wr_vld = 0;
    chk("fp_level", level, 16);
    chk("fp_drop", drop_cnt, 2);

    // drain remaining 17 records in order
    for (int k = 0; k < 17; k++) begin
      r = exp_q.pop_front();
      chk($sformatf("drain%0d_hi", k), {rd_vld, rd_hi, rd_data},
          {2'b11, r[63:32]});
      tick();
      chk($sformatf("drain%0d_lo", k), {rd_vld, rd_hi, rd_data},
          {2'b10, r[31:0]});
      tick();
    end
    chk("drain_idle", rd_vld, 0);
    chk("drain_level", level, 0);
    chk("drain_ovf", ovf, 1);
    rd_ack = 0;

    // flush in LO with 5 queued and a concurrent write
    for (int i = 0; i < 6; i++) begin
      wr_vld = 1; wr_data = rec(100 + i);
      tick();
    end
    wr_vld = 0;
    chk("fl_level5", level, 5);
    rd_ack = 1;
    tick();
    rd_ack = 0;
    chk("fl_inlo", {rd_vld, rd_hi}, 2'b10);
    flush = 1; wr_vld = 1; wr_data = rec(200);
    tick();
    flush = 0; wr_vld = 0;
    chk("fl_vld", rd_vld, 0);
    chk("fl_level", level, 0);
    chk("fl_drop", drop_cnt, 2);
    chk("fl_ovf", ovf, 1);
    tick();
    chk("fl_stay_empty", level, 0);
    wr_vld = 1; wr_data = 64'h1111_2222_3333_4444;
    tick();
    wr_vld = 0;
    chk("fl_new_level", level, 1);
    tick();
    chk("fl_new_hi", {rd_vld, rd_hi, rd_data}, {2'b11, 32'h1111_2222});
    rd_ack = 1;
    tick();
    chk("fl_new_lo", {rd_vld, rd_hi, rd_data}, {2'b10, 32'h3333_4444});
    tick();
    chk("fl_new_idle", rd_vld, 0);
    rd_ack = 0;

    // clear overflow
    clr_ovf = 1;
    tick();
    clr_ovf = 0;
    chk("clr_ovf", ovf, 0);
    chk("clr_drop", drop_cnt, 0);

    // reset in HI with 3 queued
    for (int i = 0; i < 4; i++) begin
      wr_vld = 1; wr_data = rec(300 + i);
      tick();
    end
    wr_vld = 0;
    chk("rs_level3", level, 3);
    chk("rs_inhi", {rd_vld, rd_hi}, 2'b11);
    RESET = 1;
    tick();
    RESET = 0;
    chk("rs_out", {rd_vld, rd_hi, rd_data, level, ovf, drop_cnt}, '0);
    wr_vld = 1; wr_data = 64'hAAAA_5555_0F0F_F0F0;
    tick();
    wr_vld = 0;
    chk("rs_t1", {rd_vld, level}, {1'b0, 5'd1});
    tick();
    chk("rs_t2", {rd_vld, rd_hi, rd_data}, {2'b11, 32'hAAAA_5555});

    // saturation on the 2-bit counter instance
    for (int i = 0; i < 17; i++) begin
      wr_vld2 = 1; wr_data = rec(400 + i);
      tick();
    end
    chk("sat_full", level2, 16);
    chk("sat_nodrop", drop_cnt2, 0);
    for (int i = 0; i < 2; i++) tick();
    chk("sat_two", drop_cnt2, 2);
    for (int i = 0; i < 4; i++) tick();
    chk("sat_cnt", drop_cnt2, 3);
    chk("sat_ovf", ovf2, 1);
    clr_ovf2 = 1;
    tick();
    wr_vld2 = 0;
    chk("sat_clr_drop_ovf", ovf2, 1);
    chk("sat_clr_drop_cnt", drop_cnt2, 1);
    tick();
    clr_ovf2 = 0;
    chk("sat_clr_ovf", ovf2, 0);
    chk("sat_clr_cnt", drop_cnt2, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
